// File: rtl/pong_ball_engine_if.sv
// Control inputs and ball/score outputs of the Pong ball engine.
// The driver (game top level or bench) uses master; the engine uses slave.
interface pong_ball_engine_if #(
  parameter int CW = 10,
  parameter int SW = 4
);
  logic          game_tick;
  logic          start;
  logic [CW-1:0] y_paddleA;
  logic [CW-1:0] y_paddleB;
  logic [CW-1:0] x_ball;
  logic [CW-1:0] y_ball;
  logic [SW-1:0] score_a;
  logic [SW-1:0] score_b;
  logic          point_a;
  logic          point_b;
  logic [1:0]    state;
  logic          game_over;
  logic          winner;

  modport master (
    output game_tick, start, y_paddleA, y_paddleB,
    input  x_ball, y_ball, score_a, score_b, point_a, point_b, state, game_over, winner
  );

  modport slave (
    input  game_tick, start, y_paddleA, y_paddleB,
    output x_ball, y_ball, score_a, score_b, point_a, point_b, state, game_over, winner
  );
endinterface

// File: rtl/pong_ball_engine.sv
// Pong ball physics and match flow: position, signed velocity, wall/paddle
// bounces, scoring and serve/point/game-over sequencing, one step per game_tick.
module pong_ball_engine #(
  parameter int CW          = 10,
  parameter int SW          = 4,
  parameter int BALL_W      = 10,
  parameter int BALL_H      = 10,
  parameter int PAD_W       = 12,
  parameter int PAD_H       = 100,
  parameter int Y_CEIL      = 48,
  parameter int Y_FLOOR     = 432,
  parameter int X_LWALL     = 64,
  parameter int X_RWALL     = 576,
  parameter int X_PADA      = 100,
  parameter int X_PADB      = 530,
  parameter int SERVE_X     = 315,
  parameter int SERVE_Y     = 235,
  parameter int VX0         = 2,
  parameter int VY          = 1,
  parameter int VMAX        = 6,
  parameter int PAUSE_TICKS = 60,
  parameter int WIN_SCORE   = 7
) (
  input logic              vga_clk,
  input logic              rst_n,
  pong_ball_engine_if.slave bus
);
  localparam int NW = CW + 2;
  localparam int TW = $clog2(PAUSE_TICKS + 1);

  localparam logic signed [NW-1:0] K_ONE    = NW'(1);
  localparam logic signed [NW-1:0] K_BW     = NW'(BALL_W);
  localparam logic signed [NW-1:0] K_BH     = NW'(BALL_H);
  localparam logic signed [NW-1:0] K_PH     = NW'(PAD_H);
  localparam logic signed [NW-1:0] K_CEIL   = NW'(Y_CEIL);
  localparam logic signed [NW-1:0] K_FLOOR  = NW'(Y_FLOOR);
  localparam logic signed [NW-1:0] K_LWALL  = NW'(X_LWALL);
  localparam logic signed [NW-1:0] K_RWALL  = NW'(X_RWALL);
  localparam logic signed [NW-1:0] K_PADA_R = NW'(X_PADA + PAD_W);
  localparam logic signed [NW-1:0] K_PADB   = NW'(X_PADB);
  localparam logic signed [NW-1:0] K_VX0    = NW'(VX0);
  localparam logic signed [NW-1:0] K_VY     = NW'(VY);
  localparam logic signed [NW-1:0] K_VMAX   = NW'(VMAX);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER} st_t;

  st_t                   st_reg, st_next;
  logic [CW-1:0]         x_reg, x_next, y_reg, y_next;
  logic signed [NW-1:0]  vx_reg, vx_next;
  logic                  vy_neg_reg, vy_neg_next;
  logic [SW-1:0]         sa_reg, sa_next, sb_reg, sb_next;
  logic                  pa_reg, pa_next, pb_reg, pb_next;
  logic                  win_reg, win_next;
  logic [TW-1:0]         tcnt_reg, tcnt_next;

  logic signed [NW-1:0]  x_s, nx, ny, vx_mag, vx_inc, vx_fast, pya, pyb;
  logic                  vx_neg, vx_pos, pad_a_vert, pad_b_vert, pause_done;

  // Next position is computed two bits wider and signed so edges never wrap.
  always_comb begin
    x_s        = $signed({2'b00, x_reg});
    nx         = x_s + vx_reg;
    ny         = vy_neg_reg ? $signed({2'b00, y_reg}) - K_VY : $signed({2'b00, y_reg}) + K_VY;
    vx_neg     = vx_reg[NW-1];
    vx_pos     = !vx_reg[NW-1] && (vx_reg != '0);
    vx_mag     = vx_neg ? -vx_reg : vx_reg;
    vx_inc     = vx_mag + K_ONE;
    vx_fast    = (vx_inc > K_VMAX) ? K_VMAX : vx_inc;
    pya        = $signed({2'b00, bus.y_paddleA});
    pyb        = $signed({2'b00, bus.y_paddleB});
    pad_a_vert = (ny + K_BH > pya) && (ny < pya + K_PH);
    pad_b_vert = (ny + K_BH > pyb) && (ny < pyb + K_PH);
    pause_done = bus.game_tick && (tcnt_reg == TW'(PAUSE_TICKS - 1));
  end

  always_comb begin
    st_next     = st_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    vx_next     = vx_reg;
    vy_neg_next = vy_neg_reg;
    sa_next     = sa_reg;
    sb_next     = sb_reg;
    pa_next     = 1'b0;
    pb_next     = 1'b0;
    win_next    = win_reg;
    tcnt_next   = '0;

    case (st_reg)
      S_IDLE: begin
        x_next = CW'(SERVE_X);
        y_next = CW'(SERVE_Y);
        if (bus.start) begin
          st_next     = S_SERVE;
          vx_next     = K_VX0;
          vy_neg_next = 1'b0;
        end
      end

      S_SERVE: begin
        if (pause_done) begin
          st_next = S_PLAY;
        end else begin
          tcnt_next = bus.game_tick ? tcnt_reg + TW'(1) : tcnt_reg;
        end
      end

      S_PLAY: begin
        if (bus.game_tick) begin
          if (vx_neg && nx <= K_LWALL) begin
            sb_next  = sb_reg + SW'(1);
            pb_next  = 1'b1;
            win_next = 1'b1;
            st_next  = S_POINT;
          end else if (vx_pos && nx + K_BW >= K_RWALL) begin
            sa_next  = sa_reg + SW'(1);
            pa_next  = 1'b1;
            win_next = 1'b0;
            st_next  = S_POINT;
          end else begin
            if (ny <= K_CEIL) begin
              y_next      = CW'(Y_CEIL);
              vy_neg_next = 1'b0;
            end else if (ny + K_BH >= K_FLOOR) begin
              y_next      = CW'(Y_FLOOR - BALL_H);
              vy_neg_next = 1'b1;
            end else begin
              y_next = ny[CW-1:0];
            end
            x_next = nx[CW-1:0];
            // Paddle faces are tested against the pre-tick x so a fast ball cannot tunnel through.
            if (vx_neg && x_s >= K_PADA_R && nx < K_PADA_R && pad_a_vert) begin
              x_next  = CW'(X_PADA + PAD_W);
              vx_next = vx_fast;
            end else if (vx_pos && x_s + K_BW <= K_PADB && nx + K_BW > K_PADB && pad_b_vert) begin
              x_next  = CW'(X_PADB - BALL_W);
              vx_next = -vx_fast;
            end
          end
        end
      end

      S_POINT: begin
        if (pause_done) begin
          x_next  = CW'(SERVE_X);
          y_next  = CW'(SERVE_Y);
          // win_reg holds the last scorer; the serve goes toward the other player.
          vx_next = win_reg ? -K_VX0 : K_VX0;
          if ((win_reg ? sb_reg : sa_reg) == SW'(WIN_SCORE)) begin
            st_next = S_OVER;
          end else begin
            st_next = S_SERVE;
          end
        end else begin
          tcnt_next = bus.game_tick ? tcnt_reg + TW'(1) : tcnt_reg;
        end
      end

      S_OVER: begin
        if (bus.start) begin
          sa_next = '0;
          sb_next = '0;
          vx_next = K_VX0;
          st_next = S_SERVE;
        end
      end

      default: st_next = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      st_reg     <= S_IDLE;
      x_reg      <= CW'(SERVE_X);
      y_reg      <= CW'(SERVE_Y);
      vx_reg     <= K_VX0;
      vy_neg_reg <= 1'b0;
      sa_reg     <= '0;
      sb_reg     <= '0;
      pa_reg     <= 1'b0;
      pb_reg     <= 1'b0;
      win_reg    <= 1'b0;
      tcnt_reg   <= '0;
    end else begin
      st_reg     <= st_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      vx_reg     <= vx_next;
      vy_neg_reg <= vy_neg_next;
      sa_reg     <= sa_next;
      sb_reg     <= sb_next;
      pa_reg     <= pa_next;
      pb_reg     <= pb_next;
      win_reg    <= win_next;
      tcnt_reg   <= tcnt_next;
    end
  end

  assign bus.x_ball    = x_reg;
  assign bus.y_ball    = y_reg;
  assign bus.score_a   = sa_reg;
  assign bus.score_b   = sb_reg;
  assign bus.point_a   = pa_reg;
  assign bus.point_b   = pb_reg;
  assign bus.state     = (st_reg == S_OVER) ? 2'd3 : st_reg[1:0];
  assign bus.game_over = (st_reg == S_OVER);
  assign bus.winner    = win_reg;
endmodule

// File: doc/pong_ball_engine.md
# pong_ball_engine

Parametrised successor to the fixed-position ball controller: owns ball position, signed velocity, wall/paddle collisions, scoring and match flow for the Pong top level. Advances one physics step per `game_tick` pulse from `GameTickGen`, in the `vga_clk` domain. Feeds `x_ball`/`y_ball` to `DisplayController`. Adds serve/pause/game-over sequencing and per-hit ball speed-up.

## Interface
- CW, 10, coordinate width
- SW, 4, score counter width
- BALL_W / BALL_H, 10 / 10, ball size in pixels
- PAD_W / PAD_H, 12 / 100, paddle size
- Y_CEIL / Y_FLOOR, 48 / 432, playfield top/bottom
- X_LWALL / X_RWALL, 64 / 576, goal lines
- X_PADA / X_PADB, 100 / 530, paddle left edges
- SERVE_X / SERVE_Y, 315 / 235, serve position
- VX0 / VY, 2 / 1, initial horizontal step, fixed vertical step magnitude
- VMAX, 6, horizontal step ceiling
- PAUSE_TICKS, 60, ticks spent in SERVE and POINT
- WIN_SCORE, 7, points to win
- vga_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- game_tick  in  1  one-cycle step enable
- start  in  1  one-cycle start/restart pulse
- y_paddleA, y_paddleB  in  CW  paddle top edges
- x_ball, y_ball  out  CW  ball top-left corner
- score_a, score_b  out  SW  scores
- point_a, point_b  out  1  one-cycle pulse when A/B scores
- state  out  2  IDLE=0, SERVE=1, PLAY=2, POINT=3; OVER reported as 3 with game_over=1
- game_over  out  1  high in OVER
- winner  out  1  0=A, 1=B; valid while game_over

## Operation
- States: IDLE, SERVE, PLAY, POINT, OVER. Reset → IDLE.
- IDLE: ball held at SERVE_X/SERVE_Y. `start` → SERVE with vx=+VX0 (toward B), vy=+VY.
- SERVE: ball held at serve position; tick counter counts `game_tick`; at the PAUSE_TICKS-th tick → PLAY.
- PLAY, per tick: nx=x+vx, ny=y+vy, computed signed in CW+2 bits (no wrap).
  - Score priority: vx<0 and nx<=X_LWALL → B scores; vx>0 and nx+BALL_W>=X_RWALL → A scores. Ball frozen at pre-tick position, score++, point pulse, → POINT. All other collision checks ignored that tick.
  - Ceiling: ny<=Y_CEIL → y=Y_CEIL, vy=+VY. Floor: ny+BALL_H>=Y_FLOOR → y=Y_FLOOR-BALL_H, vy=-VY.
  - Paddle A: vx<0, x>=X_PADA+PAD_W, nx<X_PADA+PAD_W, ny+BALL_H>y_paddleA, ny<y_paddleA+PAD_H → x=X_PADA+PAD_W, vx=+min(|vx|+1,VMAX).
  - Paddle B mirror: vx>0, x+BALL_W<=X_PADB, nx+BALL_W>X_PADB, same vertical test with y_paddleB → x=X_PADB-BALL_W, vx=-min(|vx|+1,VMAX).
  - Wall and paddle hit in same tick: both corrections applied.
- POINT: ball frozen for PAUSE_TICKS ticks, then ball → serve position, |vx|=VX0 aimed at the player who lost the point, vy sign kept. If the scorer's score==WIN_SCORE → OVER (winner set) else SERVE.
- OVER: everything held. `start` → scores cleared, game_over=0, → SERVE, vx=+VX0.
- `start` ignored in SERVE/PLAY/POINT. Tick counter cleared on every state entry.
- Paddle inputs sampled only on tick cycles; out-of-range paddle values are used unchecked.

## Timing
- All outputs registered; reset values: x_ball=SERVE_X, y_ball=SERVE_Y, scores 0, point_a/b 0, state IDLE, game_over 0, winner 0.
- Position/state update visible the cycle after the `game_tick` cycle (latency 1).
- `start` and `game_tick` in the same IDLE/OVER cycle: transition taken, tick not counted.
- point_a/point_b high exactly one cycle, same cycle score changes.
- rst_n asserted mid-game: immediate return to reset values, no pulse emitted.

## Test plan
- Reset, start, 60 ticks → state=PLAY; next tick x_ball=317, y_ball=236.
- PLAY, y=49, vy=-1, one tick → y_ball=48, vy=+1; ball at y=421, vy=+1 → y_ball=422, vy=-1.
- Ball x=113, vx=-2, y_paddleA=200, y=250, one tick → x_ball=112, vx=+3; repeat hits until vx stays 6.
- Paddle A moved away, ball x=65, vx=-2 → score_b=1, point_b one cycle, ball frozen 60 ticks, then serve position with vx=-2.
- score_a=6, A scores → after pause game_over=1, winner=0, state=3; ticks ignored; start → scores 0, SERVE.
- rst_n low during PLAY → all outputs at reset values same cycle.
